// File: rtl/delay_line_var_pkg.sv
// Shared helpers for the variable-depth delay line.
// Pure functions only; no storage, no latency.
// No flow control of its own.
package delay_line_var_pkg;

   // Tap requests past the last stage read the last stage rather than wrapping.
   function automatic int clamp_tap(input int sel, input int max_delay);
      return (sel > max_delay) ? max_delay : sel;
   endfunction

endpackage

// File: rtl/delay_line_stage.sv
// One {valid, data} register of the delay line.
// Latency: one en-high clock edge from v_i/d_i to v_o/d_o.
// Holds when en is low; flush clears only the valid bit and keeps data.
module delay_line_stage #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic             v_i,
   input  logic [WIDTH-1:0] d_i,
   output logic             v_o,
   output logic [WIDTH-1:0] d_o
);

   logic             v_q, v_d;
   logic [WIDTH-1:0] d_q, d_d;

   // Next state: flush beats advance, and a flushed cycle drops the incoming sample.
   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (flush) begin
         v_d = 1'b0;
      end else if (en) begin
         v_d = v_i;
         d_d = d_i;
      end
   end

   // Stage register; reset clears data too so no X ever reaches the tap mux.
   always_ff @(posedge clk) begin
      if (reset) begin
         v_q <= 1'b0;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign v_o = v_q;
   assign d_o = d_q;

endmodule

// File: rtl/delay_line_var.sv
// Delay line with runtime-selected tap depth, valid bit, stall and flush.
// Latency: delay_sel en-high edges (0 = combinational passthrough).
// en low stalls every stage; the input is ignored while stalled.
module delay_line_var
   import delay_line_var_pkg::*;
#(
   parameter  int WIDTH     = 16,
   parameter  int MAX_DELAY = 8,
   localparam int SEL_WIDTH = $clog2(MAX_DELAY + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 flush,
   input  logic [SEL_WIDTH-1:0] delay_sel,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out,
   output logic                 busy
);

   logic [MAX_DELAY-1:0] stage_v;
   logic [WIDTH-1:0]     stage_d [MAX_DELAY];
   int                   tap;

   for (genvar i = 0; i < MAX_DELAY; i++) begin : g_stage
      logic             v_in;
      logic [WIDTH-1:0] d_in;

      if (i == 0) begin : g_head
         assign v_in = in_valid;
         assign d_in = in;
      end else begin : g_link
         assign v_in = stage_v[i-1];
         assign d_in = stage_d[i-1];
      end

      delay_line_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk   (clk),
         .reset (reset),
         .en    (en),
         .flush (flush),
         .v_i   (v_in),
         .d_i   (d_in),
         .v_o   (stage_v[i]),
         .d_o   (stage_d[i])
      );
   end

   // Tap mux: tap 0 bypasses the registers, tap k reads stage k-1, oversize taps clamp.
   always_comb begin
      tap       = clamp_tap(32'(delay_sel), MAX_DELAY);
      out_valid = in_valid;
      out       = in;
      for (int k = 1; k <= MAX_DELAY; k++) begin
         if (tap == k) begin
            out_valid = stage_v[k-1];
            out       = stage_d[k-1];
         end
      end
   end

   // Anything still in flight, regardless of which tap is being read.
   always_comb begin
      busy = |stage_v;
   end

endmodule
